// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains the 16x8 byte FIFO into SDRAM write bursts.
// Stages up to BURST_LEN popped bytes, issues one burst request, then
// streams the staged bytes as valid/ready data beats.
module fifo_burst_reader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              flush,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_len,
  output logic              wdata_valid,
  input  logic              wdata_ready,
  output logic [DATA_W-1:0] wdata,
  output logic              wdata_last,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_DATA
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] stage_buf [BURST_LEN];
  logic [CNT_W-1:0]  filled;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  idx;
  logic              pending;
  logic              flush_lat;

  logic [CNT_W-1:0]  filled_nxt;
  logic              flush_act;
  logic              fill_done;
  logic              flush_go;

  // Pop only while filling, never on empty, never past a full burst or while a flush drains.
  assign fifo_rd_en = (state == ST_FILL) & enable & ~fifo_empty & ~flush_lat & (issued < FULL);

  // Staged count once the in-flight byte (if any) lands this cycle.
  assign filled_nxt = filled + CNT_W'(pending);
  assign flush_act  = flush_lat | flush;
  assign fill_done  = ~fifo_rd_en & (filled_nxt == FULL);
  assign flush_go   = ~fifo_rd_en & flush_act & (filled_nxt != '0);

  // Control FSM with registered request/beat outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      req_valid   <= 1'b0;
      req_addr    <= ADDR_W'(BASE_ADDR);
      req_len     <= '0;
      wdata_valid <= 1'b0;
      wdata       <= '0;
      wdata_last  <= 1'b0;
      filled      <= '0;
      issued      <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      flush_lat   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (flush) flush_lat <= 1'b1;
          if (enable) begin
            state <= ST_FILL;
            busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          pending <= fifo_rd_en;
          filled  <= filled_nxt;
          if (fifo_rd_en) issued <= issued + CNT_W'(1);
          if (fill_done || flush_go) begin
            state     <= ST_REQ;
            req_valid <= 1'b1;
            req_len   <= filled_nxt;
            flush_lat <= 1'b0;
          end else if (flush_act) begin
            // A flush with nothing staged retires unless a pop is still in flight.
            flush_lat <= fifo_rd_en;
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            state       <= ST_DATA;
            req_valid   <= 1'b0;
            wdata_valid <= 1'b1;
            wdata       <= stage_buf[IDX_W'(0)];
            wdata_last  <= (req_len == CNT_W'(1));
            idx         <= '0;
          end
        end
        ST_DATA: begin
          if (wdata_ready) begin
            if (wdata_last) begin
              wdata_valid <= 1'b0;
              wdata_last  <= 1'b0;
              req_addr    <= req_addr + ADDR_W'(req_len);
              filled      <= '0;
              issued      <= '0;
              idx         <= '0;
              state       <= enable ? ST_FILL : ST_IDLE;
              busy        <= enable;
            end else begin
              idx        <= idx + CNT_W'(1);
              wdata      <= stage_buf[IDX_W'(idx + CNT_W'(1))];
              wdata_last <= ((idx + CNT_W'(2)) == req_len);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Capture the FIFO byte the cycle after its pop was accepted.
  always_ff @(posedge clk) begin
    if (state == ST_FILL && pending) stage_buf[IDX_W'(filled)] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scenarios plus a randomized run, checked
// against a byte-stream/address reference model kept in the bench.
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, flush, req_ready, wdata_ready;
  logic        fifo_rd_en, fifo_empty, req_valid, wdata_valid, wdata_last, busy;
  logic [7:0]  fifo_rd_data, wdata;
  logic [11:0] req_addr;
  logic [3:0]  req_len;

  logic        w_enable, w_rd_en, w_req_valid, w_wdata_valid, w_wdata_last, w_busy;
  logic [7:0]  w_rd_data, w_wdata, w_cnt, w_beat_exp;
  logic [11:0] w_req_addr;
  logic [3:0]  w_req_len;
  int          w_reqs = 0;

  fifo_burst_reader #(.DATA_W(8), .BURST_LEN(4), .ADDR_W(12), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .wdata_last(wdata_last), .busy(busy)
  );

  fifo_burst_reader #(.DATA_W(8), .BURST_LEN(4), .ADDR_W(12), .BASE_ADDR(4092)) u_wrap (
    .clk(clk), .reset_n(reset_n), .enable(w_enable), .flush(1'b0),
    .fifo_rd_en(w_rd_en), .fifo_rd_data(w_rd_data), .fifo_empty(1'b0),
    .req_valid(w_req_valid), .req_ready(1'b1), .req_addr(w_req_addr), .req_len(w_req_len),
    .wdata_valid(w_wdata_valid), .wdata_ready(1'b1), .wdata(w_wdata),
    .wdata_last(w_wdata_last), .busy(w_busy)
  );

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  int         pops = 0;
  int         pop_cyc[$];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_bytes[$];
  int         exp_len_q[$];
  int         exp_addr = 0;
  int         bursts_done = 0;
  int         reqs_seen = 0;
  int         req_rise_cyc = -1;
  logic       mon_in_burst = 1'b0;
  int         mon_len = 0;
  int         mon_beat = 0;
  int         exp_len;
  logic [31:0] exp_b;
  logic        rand_mode = 1'b0;

  logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0, prev_wl = 1'b0;
  logic [11:0] prev_addr = '0;
  logic [3:0]  prev_len = '0;
  logic [7:0]  prev_wd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Registered-output FIFO model for the main instance.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_rd_data <= fifo_q.pop_front();
      pop_cyc.push_back(cyc);
      pops++;
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (w_rd_en) begin
      w_rd_data <= w_cnt;
      w_cnt = w_cnt + 8'd1;
    end
    cyc++;
  end

  // Protocol and data monitor for the main instance.
  always @(negedge clk) begin
    if (!reset_n) begin
      if (mon_in_burst) repeat (mon_len - mon_beat) void'(exp_bytes.pop_front());
      mon_in_burst = 1'b0;
      mon_beat     = 0;
      exp_addr     = 0;
      prev_rv      = 1'b0;
      prev_wv      = 1'b0;
    end else begin
      if (fifo_empty) check("rd_en_on_empty", 32'(fifo_rd_en), 0);
      if (req_valid || wdata_valid) check("valid_exclusive", 32'(req_valid & wdata_valid), 0);
      if (prev_rv && !prev_rr) check("req_hold", {req_valid, req_addr, req_len}, {1'b1, prev_addr, prev_len});
      if (prev_wv && !prev_wr) check("wdata_hold", {wdata_valid, wdata, wdata_last}, {1'b1, prev_wd, prev_wl});
      if (req_valid && !prev_rv) req_rise_cyc = cyc;
      if (req_valid && req_ready) begin
        reqs_seen++;
        check("req_addr", 32'(req_addr), 32'(exp_addr));
        exp_len = (exp_len_q.size() != 0) ? exp_len_q.pop_front() : 0;
        check("req_len", 32'(req_len), 32'(exp_len));
        mon_in_burst = 1'b1;
        mon_len      = int'(req_len);
        mon_beat     = 0;
      end
      if (wdata_valid && wdata_ready) begin
        if (!mon_in_burst) begin
          check("beat_outside_burst", 32'(wdata_valid), 0);
        end else begin
          exp_b = (exp_bytes.size() != 0) ? 32'(exp_bytes.pop_front()) : 32'h100;
          check("beat_data", 32'(wdata), exp_b);
          check("beat_last", 32'(wdata_last), 32'(mon_beat == mon_len - 1));
          mon_beat++;
          if (mon_beat == mon_len) begin
            mon_in_burst = 1'b0;
            bursts_done++;
            exp_addr = (exp_addr + mon_len) % 4096;
          end
        end
      end
      prev_rv = req_valid;  prev_rr = req_ready;
      prev_wv = wdata_valid; prev_wr = wdata_ready;
      prev_addr = req_addr; prev_len = req_len;
      prev_wd = wdata; prev_wl = wdata_last;
    end
  end

  // Monitor for the wrap instance: consecutive full bursts from 4092.
  always @(negedge clk) begin
    if (reset_n) begin
      if (w_req_valid) begin
        check("wrap_addr", 32'(w_req_addr), 32'((4092 + 4 * w_reqs) % 4096));
        check("wrap_len", 32'(w_req_len), 4);
        w_reqs++;
      end
      if (w_wdata_valid) begin
        check("wrap_data", 32'(w_wdata), 32'(w_beat_exp));
        w_beat_exp = w_beat_exp + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      req_ready   = 1'($urandom_range(0, 1));
      wdata_ready = 1'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_bytes.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input int budget);
    int n = 0;
    while (bursts_done < target && n < budget) begin
      tick();
      n++;
    end
    check("burst_count", 32'(bursts_done), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int p;
    int r;
    int k;
    int target;
    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; req_ready = 1'b1; wdata_ready = 1'b1;
    w_enable = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0; w_rd_data = '0;
    w_cnt = '0; w_beat_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(req_valid), 0);
    check("rst_wdata_valid", 32'(wdata_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_req_addr", 32'(req_addr), 0);
    check("rst_wrap_addr", 32'(w_req_addr), 4092);
    reset_n = 1'b1;
    tick();

    // 1: full burst of four preloaded bytes
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    exp_len_q.push_back(4);
    n0 = pop_cyc.size();
    enable = 1'b1;
    target = 1;
    wait_bursts(target, 200);
    check("t1_pops", 32'(pop_cyc.size() - n0), 4);
    if (pop_cyc.size() >= n0 + 4) begin
      check("t1_pop_spacing", 32'(pop_cyc[n0 + 3] - pop_cyc[n0]), 3);
      check("t1_req_latency", 32'(req_rise_cyc - pop_cyc[n0]), 5);
    end
    check("t1_next_addr", 32'(req_addr), 4);

    // 2: partial burst forced out by flush
    r = reqs_seen;
    push(8'hA0); push(8'hA1);
    exp_len_q.push_back(2);
    repeat (8) tick();
    check("t2_no_req_before_flush", 32'(reqs_seen), 32'(r));
    flush = 1'b1; tick(); flush = 1'b0;
    target++;
    wait_bursts(target, 100);
    check("t2_next_addr", 32'(req_addr), 6);
    r = reqs_seen;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (10) tick();
    check("t2_empty_flush_no_req", 32'(reqs_seen), 32'(r));
    check("t2_empty_flush_valid", 32'(req_valid), 0);
    check("t2_busy_in_fill", 32'(busy), 1);

    // 3: request and beat stalls
    req_ready = 1'b0; wdata_ready = 1'b0;
    push(8'h5A); push(8'hC3); push(8'h0F); push(8'hF0);
    exp_len_q.push_back(4);
    k = 0;
    while (!req_valid && k < 50) begin tick(); k++; end
    check("t3_req_seen", 32'(req_valid), 1);
    repeat (5) tick();
    check("t3_req_held", {req_valid, req_addr, req_len}, {1'b1, 12'd6, 4'd4});
    req_ready = 1'b1;
    tick();
    target++;
    k = 0;
    while (bursts_done < target && k < 40) begin
      wdata_ready = (k % 2 == 0);
      tick();
      k++;
    end
    check("burst_count", 32'(bursts_done), 32'(target));
    req_ready = 1'b1; wdata_ready = 1'b1;
    check("t3_next_addr", 32'(req_addr), 10);

    // 4: address wrap on the second instance
    w_enable = 1'b1;
    repeat (25) tick();
    w_enable = 1'b0;
    repeat (15) tick();
    check("t4_wrap_bursts", 32'(w_reqs >= 2), 1);

    // 5: enable dropped after the second pop
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    exp_len_q.push_back(4);
    p = pops;
    r = reqs_seen;
    k = 0;
    while (pops < p + 2 && k < 30) begin tick(); k++; end
    enable = 1'b0;
    repeat (6) tick();
    check("t5_pops_held", 32'(pops), 32'(p + 2));
    if (pop_cyc.size() >= 2)
      check("t5_back_to_back", 32'(pop_cyc[pop_cyc.size() - 1] - pop_cyc[pop_cyc.size() - 2]), 1);
    check("t5_busy", 32'(busy), 1);
    check("t5_no_req", 32'(reqs_seen), 32'(r));
    enable = 1'b1;
    target++;
    wait_bursts(target, 100);
    check("t5_next_addr", 32'(req_addr), 14);

    // Randomized traffic: stalls, enable toggles, random bytes
    repeat (6) exp_len_q.push_back(4);
    rand_mode = 1'b1;
    for (int i = 0; i < 24; ) begin
      if (fifo_q.size() < 14 && $urandom_range(0, 1) == 1) begin
        push(8'($urandom));
        i++;
      end
      tick();
    end
    target += 6;
    wait_bursts(target, 3000);
    rand_mode = 1'b0;
    enable = 1'b1; req_ready = 1'b1; wdata_ready = 1'b1;
    tick();

    // 6: reset in the middle of a data phase
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    exp_len_q.push_back(4);
    k = 0;
    while (!(mon_in_burst && mon_beat == 2) && k < 60) begin tick(); k++; end
    check("t6_reached_beat2", 32'(mon_beat), 2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_outputs", {req_valid, wdata_valid, wdata_last, busy, fifo_rd_en, wdata, req_len}, '0);
    check("t6_rst_addr", 32'(req_addr), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_beats", 32'(wdata_valid), 0);
    end
    reset_n = 1'b1;
    tick();
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    exp_len_q.push_back(4);
    target++;
    wait_bursts(target, 100);
    check("t6_next_addr", 32'(req_addr), 4);
    check("t6_all_bytes_out", 32'(exp_bytes.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side drain engine for the 16x8 byte FIFO, on the FIFO's read clock.
- Pops bytes from the FIFO read port and stages up to BURST_LEN of them.
- Issues one write-burst request to the SDRAM command path, then streams the staged bytes as data beats with a valid/ready handshake.
- Auto-increments the SDRAM word address after each burst; flush forces out a partial burst.

Parameters:
- DATA_W, 8, FIFO/beat data width.
- BURST_LEN, 4, maximum beats per burst (power of two, 2..8).
- ADDR_W, 12, SDRAM burst address width; address wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, address loaded at reset.

Ports:
- clk  in  1  single clock (FIFO read clock).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permit popping from the FIFO.
- flush  in  1  single-cycle pulse: send the staged partial burst.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_rd_data  in  DATA_W  FIFO read data, registered, valid the cycle after an accepted pop.
- fifo_empty  in  1  FIFO empty flag.
- req_valid  out  1  burst request valid.
- req_ready  in  1  command path accepts the request.
- req_addr  out  ADDR_W  burst start address.
- req_len  out  4  beats in this burst, 1..BURST_LEN.
- wdata_valid  out  1  data beat valid.
- wdata_ready  in  1  data beat accepted.
- wdata  out  DATA_W  beat data.
- wdata_last  out  1  final beat of the burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0 except req_addr=BASE_ADDR.
  - Fill count, issue count, pending flag and flush latch all cleared.
  - Staged bytes are discarded. Reset in REQ or DATA aborts with no further beats.
- States: IDLE, FILL, REQ, DATA.
- IDLE: enable=1 -> FILL next cycle.
- FILL:
  - fifo_rd_en = enable & !fifo_empty & (issued < BURST_LEN). This is combinational, so a pop is never requested on empty.
  - Each pop increments issued and sets pending.
  - In the next cycle, fifo_rd_data is written to buf[filled] and filled increments.
  - Back-to-back pops give 1 byte/cycle.
- FILL -> REQ when filled==BURST_LEN and !pending.
- enable=0 in FILL: no new pops; the in-flight byte is still captured; state holds.
- flush:
  - A flush pulse in IDLE or FILL sets a flush latch.
  - While the latch is set, no new pops are issued.
  - When !pending and filled>0: go to REQ with req_len=filled; the latch clears.
  - If filled==0 and !pending, the latch clears with no request.
  - Flush in REQ or DATA is ignored.
- REQ:
  - req_valid=1; req_addr and req_len are stable until req_ready.
  - Handshake completes on the cycle req_valid & req_ready -> DATA next cycle.
- DATA:
  - wdata_valid=1, wdata=buf[idx], wdata_last=(idx==req_len-1).
  - idx advances on wdata_valid & wdata_ready; outputs hold while wdata_ready=0.
  - On accepting the last beat:
    - req_addr <= req_addr + req_len, mod 2^ADDR_W, so 4094+4 -> 2.
    - Counters clear.
    - Next state is FILL if enable, else IDLE.
- req_valid and wdata_valid are never high in the same cycle.
- Throughput: a full burst with ready tied high = BURST_LEN pop cycles + 1 capture + 1 REQ + BURST_LEN DATA cycles.
- Byte order is preserved FIFO -> beats. No byte is lost or duplicated across stalls, enable toggles or flush.

Test Plan:
1. FIFO preloaded with 0x11,0x22,0x33,0x44, enable=1, ready high -> 4 consecutive fifo_rd_en.
   - req_valid with req_addr=0, req_len=4.
   - wdata 0x11,0x22,0x33,0x44 with last on 0x44.
   - req_addr becomes 4.
2. Two bytes 0xA0,0xA1 then fifo_empty, flush pulse -> req_len=2, beats 0xA0,0xA1 with last on 0xA1, address advances by 2.
   - A second flush with nothing staged -> no req_valid.
3. Stalls: req_ready low 5 cycles, then wdata_ready toggling 1,0,1,0 -> req_addr/req_len and wdata held stable while not ready; beat order unchanged.
4. Wrap: BASE_ADDR=4092, two full bursts -> req_addr 4092 then 0.
5. Pops 1 byte/cycle with enable dropped after the 2nd pop -> only 2 bytes captured, state stays FILL, busy=1.
   - Re-enable: remaining 2 bytes popped, one burst emitted.
6. reset_n asserted mid-DATA after beat 2 -> all outputs 0 immediately, req_addr=BASE_ADDR, no further beats.
   - After release, a fresh burst starts from a new FIFO byte.
